// File: rtl/mps_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mps_display_pkg
// Description : Shared constants, BCD digit type and 7-segment decode.
// Revision    : 1.0 - initial release
// ============================================================================
package mps_display_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // Active-low g..a in [6:0], DP (bit 7) held off.
    localparam logic [7:0] SEG_LUT [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    typedef logic [3:0] bcd_digit_t;

    function automatic logic [7:0] seg_decode(input bcd_digit_t d);
        logic [7:0] v_seg;
        if (d > 4'd9) begin
            v_seg = SEG_DASH;
        end else begin
            v_seg = SEG_LUT[d];
        end
        return v_seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : Multiplexed 7-segment driver; anode and segment registers
//               update together from the current digit index.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver
    import mps_display_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_scan_tick,
    input  logic [4*NUM_DIGITS-1:0]   i_bcd_value,
    output logic [NUM_DIGITS-1:0]     o_seg_select,
    output logic [7:0]                o_hex
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_one = NUM_DIGITS'(1);

    logic [IDX_W-1:0]      r_index;
    logic [NUM_DIGITS-1:0] r_seg_select;
    logic [7:0]            r_hex;
    bcd_digit_t            w_digit;

    assign w_digit = i_bcd_value[{r_index, 2'b00} +: 4];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_index      <= '0;
            r_seg_select <= '1;
            r_hex        <= SEG_BLANK;
        end else begin
            if (i_scan_tick) begin
                r_index <= (r_index == c_idx_last) ? '0 : r_index + IDX_W'(1);
            end
            // Both registers derive from the same index so anode and segments never disagree.
            r_seg_select <= ~(c_one << r_index);
            r_hex        <= seg_decode(w_digit);
        end
    end

    assign o_seg_select = r_seg_select;
    assign o_hex        = r_hex;

endmodule
`default_nettype wire

// File: rtl/mps_display_top.sv
`default_nettype none
// ============================================================================
// Module      : mps_display_top
// Description : Demo board top: lock indicator, 1 Hz heartbeat and a BCD
//               seconds count on a 4-digit multiplexed display.
// Revision    : 1.0 - initial release
// ============================================================================
module mps_display_top
    import mps_display_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int HEARTBEAT_HZ = 1,
    parameter int SCAN_HZ      = 1000,
    parameter int LOCK_CYCLES  = 1024
)
(
    input  logic                  CLK100_IN,
    input  logic                  HARD_RST,
    output logic [NUM_DIGITS-1:0] SEG_SELECT_OUT,
    output logic [7:0]            HEX_OUT,
    output logic                  LED15_LOCKED,
    output logic                  LED14_1HZ
);

    localparam int HALF     = CLK_FREQ_HZ / (2 * HEARTBEAT_HZ);
    localparam int SCAN_DIV = CLK_FREQ_HZ / SCAN_HZ;
    localparam int LOCK_W   = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int HB_W     = (HALF > 1)        ? $clog2(HALF)        : 1;
    localparam int SCAN_W   = (SCAN_DIV > 1)    ? $clog2(SCAN_DIV)    : 1;

    localparam logic [LOCK_W-1:0] c_lock_last = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [HB_W-1:0]   c_hb_last   = HB_W'(HALF - 1);
    localparam logic [SCAN_W-1:0] c_scan_last = SCAN_W'(SCAN_DIV - 1);

    logic [LOCK_W-1:0] r_lock_cnt;
    logic              r_locked;
    logic [HB_W-1:0]   r_hb_cnt;
    logic              r_led14;
    logic [SCAN_W-1:0] r_scan_cnt;
    bcd_digit_t [NUM_DIGITS-1:0] r_bcd;
    bcd_digit_t [NUM_DIGITS-1:0] w_bcd_next;

    logic w_hold;
    logic w_hb_tick;
    logic w_sec_tick;
    logic w_scan_tick;

    // Everything downstream of the lock counter idles in reset until lock.
    assign w_hold      = HARD_RST | ~r_locked;
    assign w_hb_tick   = r_locked & (r_hb_cnt == c_hb_last);
    assign w_sec_tick  = w_hb_tick & ~r_led14;
    assign w_scan_tick = r_locked & (r_scan_cnt == c_scan_last);

    always_ff @(posedge CLK100_IN) begin
        if (HARD_RST) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (!r_locked) begin
            if (r_lock_cnt == c_lock_last) begin
                r_locked <= 1'b1;
            end else begin
                r_lock_cnt <= r_lock_cnt + LOCK_W'(1);
            end
        end
    end

    always_ff @(posedge CLK100_IN) begin
        if (w_hold) begin
            r_hb_cnt   <= '0;
            r_led14    <= 1'b0;
            r_scan_cnt <= '0;
            r_bcd      <= '0;
        end else begin
            if (w_hb_tick) begin
                r_hb_cnt <= '0;
                r_led14  <= ~r_led14;
            end else begin
                r_hb_cnt <= r_hb_cnt + HB_W'(1);
            end
            r_scan_cnt <= w_scan_tick ? '0 : r_scan_cnt + SCAN_W'(1);
            if (w_sec_tick) begin
                r_bcd <= w_bcd_next;
            end
        end
    end

    // Ripple-carry BCD increment; all-nines rolls over to zero.
    always_comb begin : p_bcd_inc
        logic v_carry;
        w_bcd_next = r_bcd;
        v_carry    = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v_carry) begin
                if (r_bcd[i] >= 4'd9) begin
                    w_bcd_next[i] = 4'd0;
                end else begin
                    w_bcd_next[i] = r_bcd[i] + 4'd1;
                    v_carry       = 1'b0;
                end
            end
        end
    end

    seg_scan_driver u_scan (
        .clk          (CLK100_IN),
        .rst          (w_hold),
        .i_scan_tick  (w_scan_tick),
        .i_bcd_value  (r_bcd),
        .o_seg_select (SEG_SELECT_OUT),
        .o_hex        (HEX_OUT)
    );

    assign LED15_LOCKED = r_locked;
    assign LED14_1HZ    = r_led14;

endmodule
`default_nettype wire

// File: tb/tb_mps_display_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_mps_display_top
// Description : Directed bench: reset, lock, scan, heartbeat, counting,
//               mid-run reset and 9999 rollover on a fast second instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mps_display_top;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [3:0] sel_a, sel_b;
    logic [7:0] hex_a, hex_b;
    logic       led15_a, led14_a, led15_b, led14_b;

    int checks = 0;
    int errors = 0;
    int j      = 0;

    always #5 clk = ~clk;

    mps_display_top #(
        .CLK_FREQ_HZ(1000), .HEARTBEAT_HZ(1), .SCAN_HZ(100), .LOCK_CYCLES(16)
    ) dut_a (
        .CLK100_IN(clk), .HARD_RST(rst_a), .SEG_SELECT_OUT(sel_a),
        .HEX_OUT(hex_a), .LED15_LOCKED(led15_a), .LED14_1HZ(led14_a)
    );

    // Half-period of 2 cycles and a scan step every cycle, so 9999 is reachable quickly.
    mps_display_top #(
        .CLK_FREQ_HZ(4), .HEARTBEAT_HZ(1), .SCAN_HZ(4), .LOCK_CYCLES(16)
    ) dut_b (
        .CLK100_IN(clk), .HARD_RST(rst_b), .SEG_SELECT_OUT(sel_b),
        .HEX_OUT(hex_b), .LED15_LOCKED(led15_b), .LED14_1HZ(led14_b)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (j=%0d)", tag, obs, exp, j);
        end
    endtask

    task automatic step();
        @(negedge clk);
        j++;
    endtask

    task automatic advance(input int target);
        while (j < target) step();
    endtask

    // Digit slot shown at sample j (cycles after lock): 10-cycle slots from j=1.
    function automatic int idx_at(input int jj);
        return ((jj - 1) / 10) % 4;
    endfunction

    function automatic logic [3:0] sel_at(input int jj);
        logic [3:0] v_one;
        v_one = 4'b0001;
        return ~(v_one << idx_at(jj));
    endfunction

    initial begin
        int         rises;
        int         budget;
        logic       prev_b;
        logic [3:0] mask;
        logic [7:0] exp_hex;

        rst_a = 1'b1;
        rst_b = 1'b1;

        repeat (5) begin
            @(negedge clk);
            check("reset", 16'({led15_a, led14_a, sel_a, hex_a}), 16'({2'b00, 4'hF, 8'hFF}));
        end

        rst_a = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            check("prelock", 16'({led15_a, sel_a}), 16'h000F);
        end
        @(negedge clk);
        check("lock_rise", 16'({led15_a, sel_a}), 16'h001F);

        j = 0;
        for (int k = 1; k <= 50; k++) begin
            step();
            check("scan_sel", 16'(sel_a), 16'(sel_at(j)));
            check("scan_hex", 16'(hex_a), 16'h00C0);
        end

        advance(499);  check("hb_low0",  16'(led14_a), 16'h0);
        step();        check("hb_rise1", 16'(led14_a), 16'h1);
        advance(999);  check("hb_high",  16'(led14_a), 16'h1);
        step();        check("hb_fall",  16'(led14_a), 16'h0);
        advance(1499); check("hb_low1",  16'(led14_a), 16'h0);
        step();        check("hb_rise2", 16'(led14_a), 16'h1);

        // Count = 3 after the third rising edge at j=2500.
        advance(2500);
        for (int k = 1; k <= 40; k++) begin
            step();
            exp_hex = (idx_at(j) == 0) ? 8'hB0 : 8'hC0;
            check("count3_hex", 16'(hex_a), 16'(exp_hex));
        end

        // Count = 0012 between j=11500 and j=12500.
        advance(11600);
        for (int k = 1; k <= 40; k++) begin
            step();
            case (idx_at(j))
                0:       exp_hex = 8'hA4;
                1:       exp_hex = 8'hF9;
                default: exp_hex = 8'hC0;
            endcase
            check("count12_hex", 16'(hex_a), 16'(exp_hex));
        end

        rst_a = 1'b1;
        @(negedge clk);
        check("midrst", 16'({led15_a, led14_a, sel_a, hex_a}), 16'({2'b00, 4'hF, 8'hFF}));
        rst_a = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            check("relock_pre", 16'({led15_a, sel_a}), 16'h000F);
        end
        @(negedge clk);
        check("relock_rise", 16'(led15_a), 16'h1);
        j = 0;
        step();
        check("relock_sel", 16'(sel_a), 16'h000E);
        check("relock_hex", 16'(hex_a), 16'h00C0);

        // Rollover on the fast instance.
        rst_b  = 1'b0;
        rises  = 0;
        budget = 0;
        prev_b = 1'b0;
        while (rises < 9999 && budget < 45000) begin
            @(negedge clk);
            budget++;
            if (led14_b && !prev_b) rises++;
            prev_b = led14_b;
        end
        check("reach_9999", 16'(rises), 16'(9999));

        mask = 4'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("all9_hex", 16'(hex_b), 16'h0090);
            mask = mask | ~sel_b;
        end
        check("all9_slots", 16'(mask), 16'h000F);

        mask = 4'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("wrap_hex", 16'(hex_b), 16'h00C0);
            mask = mask | ~sel_b;
        end
        check("wrap_slots", 16'(mask), 16'h000F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mps_display_top.md
Name: mps_display_top

Overview:
- Board-level top of the microprocessor-system demo, running on the 100 MHz oscillator clock.
- Provides a post-reset "locked" indicator and a 1 Hz heartbeat LED.
- Drives a 4-digit multiplexed 7-segment display showing a BCD seconds count.
- Every function after lock is derived from clock-enable strobes; there are no generated clocks.

Parameters:
- CLK_FREQ_HZ, 100_000_000, input clock frequency.
- HEARTBEAT_HZ, 1, LED14 square-wave frequency.
- SCAN_HZ, 1000, digit-advance rate of the display multiplexer.
- LOCK_CYCLES, 1024, cycles after reset release before LED15_LOCKED asserts.

Ports:
- CLK100_IN  input  1  single system clock, rising edge.
- HARD_RST  input  1  synchronous reset, active-high.
- SEG_SELECT_OUT  output  4  digit anodes, active-low; bit0 = rightmost (ones) digit.
- HEX_OUT  output  8  segments, active-low; [6:0] = g..a, [7] = DP.
- LED15_LOCKED  output  1  high once the lock counter has expired.
- LED14_1HZ  output  1  heartbeat square wave, 50 % duty.

Behaviour:
- Reset: HARD_RST is sampled high on a rising edge. While it is high, every cycle:
  - all counters = 0;
  - LED15_LOCKED = 0, LED14_1HZ = 0;
  - SEG_SELECT_OUT = 4'b1111, HEX_OUT = 8'hFF.
- Reset asserted mid-operation takes effect at the next edge and discards all state. The lock sequence then restarts.
- Lock:
  - A counter increments each cycle with HARD_RST low.
  - LED15_LOCKED rises at the edge that completes the LOCK_CYCLES-th such cycle and stays high until reset.
  - Until locked, heartbeat, seconds counter and scan logic are held at reset values.
- Heartbeat:
  - HALF = CLK_FREQ_HZ/(2*HEARTBEAT_HZ).
  - After lock, a divider counts 0..HALF-1; at terminal count LED14_1HZ toggles and the divider wraps to 0.
  - The first toggle (0 to 1) occurs HALF cycles after LED15_LOCKED rises.
- Seconds counter:
  - 4 BCD digits, incremented by one on each LED14 0 to 1 transition, in the same cycle as the toggle.
  - Digit carry at 9 to 0.
  - 9999 wraps to 0000.
- Scan:
  - SCAN_DIV = CLK_FREQ_HZ/SCAN_HZ.
  - After lock, the digit index 0..3 advances once per SCAN_DIV cycles and wraps 3 to 0.
  - The index starts at 0 the first cycle after lock.
- Outputs are registered:
  - SEG_SELECT_OUT = ~(1 << index).
  - HEX_OUT = decode(BCD digit[index]).
  - Both update on the same edge, one cycle after the index changes, so there is no ghosting.
- Decode (active-low, DP always off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Any value above 9 decodes to BF (dash).
- Simultaneous scan advance and seconds increment: the display shows the new count from the next refresh onward. Partial staleness within one scan slot is allowed.
- Divider widths use $clog2 of their terminal counts. No arithmetic overflow is allowed.

Decomposition:
- Package mps_display_pkg holds:
  - NUM_DIGITS = 4;
  - SEG_BLANK = 8'hFF;
  - SEG_DASH = 8'hBF;
  - the 10-entry digit-to-segment constant array;
  - a BCD digit typedef logic [3:0].
- One sub-module, seg_scan_driver: takes the 16-bit BCD value, scan strobe, clock and reset, and produces SEG_SELECT_OUT and HEX_OUT.
- Lock counter, heartbeat divider and BCD counter live in the top.

Test Plan (CLK_FREQ_HZ=1000, HEARTBEAT_HZ=1, SCAN_HZ=100, LOCK_CYCLES=16):
- Reset: HARD_RST high 5 cycles -> LED15=0, LED14=0, SEG_SELECT_OUT=1111, HEX_OUT=FF, held throughout.
- Lock: release reset -> LED15_LOCKED rises exactly 16 cycles later. Before that, SEG_SELECT_OUT stays 1111.
- Heartbeat: after lock, LED14 toggles every 500 cycles, giving a 1000-cycle period with 500 high and 500 low.
- Scan: after lock, SEG_SELECT_OUT rotates 1110 to 1101 to 1011 to 0111 to 1110, each held 10 cycles. With count 0000, HEX_OUT = C0 on every digit.
- Counting: after 3 LED14 rising edges, the digit-0 slot shows B0 (3) and the other slots show C0. Run to count 9999 -> HEX_OUT shows 90 on all digits; the next rising edge wraps the display to C0 on all digits.
- Mid-run reset: assert HARD_RST for 1 cycle at count 0012 -> next edge gives count 0, LED15=0 and select 1111. LED15 re-asserts 16 cycles after release.
